// File: rtl/decode_execute_unit_if.sv
// Decode/execute stage bus: instruction and operand inputs, decoded fields and ALU outputs.
// master drives the instruction word and register operands; slave is the stage itself.
interface decode_execute_unit_if #(
   parameter int unsigned WORD_WIDTH    = 32,
   parameter int unsigned ALUCTRL_WIDTH = 5
);
   localparam int unsigned OP_W  = 6;
   localparam int unsigned REG_W = 5;
   localparam int unsigned IMM_W = 16;

   logic [WORD_WIDTH-1:0]    instr_in;
   logic [WORD_WIDTH-1:0]    a;
   logic [WORD_WIDTH-1:0]    b;
   logic [OP_W-1:0]          op;
   logic [OP_W-1:0]          funct;
   logic [REG_W-1:0]         rs;
   logic [REG_W-1:0]         rt;
   logic [REG_W-1:0]         rd;
   logic [REG_W-1:0]         shamt;
   logic [IMM_W-1:0]         imm16;
   logic [REG_W-1:0]         wr_addr;
   logic                     reg_write;
   logic [ALUCTRL_WIDTH-1:0] alu_ctrl;
   logic [WORD_WIDTH-1:0]    c;
   logic                     z;

   modport master (
      output instr_in, a, b,
      input  op, funct, rs, rt, rd, shamt, imm16,
      input  wr_addr, reg_write, alu_ctrl, c, z
   );

   modport slave (
      input  instr_in, a, b,
      output op, funct, rs, rt, rd, shamt, imm16,
      output wr_addr, reg_write, alu_ctrl, c, z
   );
endinterface

// File: rtl/decode_execute_unit.sv
// Instruction register, MIPS-subset decoder and combinational ALU.
// The IR is the only state; decode and ALU settle from the IR and the register operands.
module decode_execute_unit #(
   parameter int unsigned WORD_WIDTH    = 32,
   parameter int unsigned ALUCTRL_WIDTH = 5
) (
   input  logic                  CLK,
   input  logic                  RST,
   decode_execute_unit_if.slave  bus
);
   localparam int unsigned OP_W    = 6;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned HALF_W  = WORD_WIDTH / 2;

   typedef enum logic [ALUCTRL_WIDTH-1:0] {
      ALU_NOP   = 5'h00,
      ALU_ADD   = 5'h01,
      ALU_SUB   = 5'h02,
      ALU_AND   = 5'h03,
      ALU_OR    = 5'h04,
      ALU_XOR   = 5'h05,
      ALU_NOR   = 5'h06,
      ALU_SLT   = 5'h07,
      ALU_SLTU  = 5'h08,
      ALU_SLL   = 5'h09,
      ALU_SRL   = 5'h0A,
      ALU_SRA   = 5'h0B,
      ALU_SLLV  = 5'h0C,
      ALU_SRLV  = 5'h0D,
      ALU_SRAV  = 5'h0E,
      ALU_ADDI  = 5'h10,
      ALU_SLTI  = 5'h11,
      ALU_SLTIU = 5'h12,
      ALU_ANDI  = 5'h13,
      ALU_ORI   = 5'h14,
      ALU_XORI  = 5'h15,
      ALU_LUI   = 5'h16
   } alu_ctrl_e;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
   localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
   localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;

   localparam logic [OP_W-1:0] FN_SLL   = 6'b000000;
   localparam logic [OP_W-1:0] FN_SRL   = 6'b000010;
   localparam logic [OP_W-1:0] FN_SRA   = 6'b000011;
   localparam logic [OP_W-1:0] FN_SLLV  = 6'b000100;
   localparam logic [OP_W-1:0] FN_SRLV  = 6'b000110;
   localparam logic [OP_W-1:0] FN_SRAV  = 6'b000111;
   localparam logic [OP_W-1:0] FN_ADD   = 6'b100000;
   localparam logic [OP_W-1:0] FN_ADDU  = 6'b100001;
   localparam logic [OP_W-1:0] FN_SUB   = 6'b100010;
   localparam logic [OP_W-1:0] FN_SUBU  = 6'b100011;
   localparam logic [OP_W-1:0] FN_AND   = 6'b100100;
   localparam logic [OP_W-1:0] FN_OR    = 6'b100101;
   localparam logic [OP_W-1:0] FN_XOR   = 6'b100110;
   localparam logic [OP_W-1:0] FN_NOR   = 6'b100111;
   localparam logic [OP_W-1:0] FN_SLT   = 6'b101010;
   localparam logic [OP_W-1:0] FN_SLTU  = 6'b101011;

   logic [WORD_WIDTH-1:0] ir_q;
   logic [WORD_WIDTH-1:0] ir_d;

   logic [OP_W-1:0]       op;
   logic [OP_W-1:0]       funct;
   logic [REG_W-1:0]      rt;
   logic [REG_W-1:0]      rd;
   logic [REG_W-1:0]      shamt;
   logic [IMM_W-1:0]      imm16;

   alu_ctrl_e             ctrl;
   logic [WORD_WIDTH-1:0] imm_sext;
   logic [WORD_WIDTH-1:0] imm_zext;
   logic [REG_W-1:0]      var_sh;
   logic [WORD_WIDTH-1:0] result;

   // Instruction register: every cycle carries a new instruction.
   assign ir_d = bus.instr_in;

   always_ff @(posedge CLK) begin
      if (RST) begin
         ir_q <= '0;
      end else begin
         ir_q <= ir_d;
      end
   end

   assign op    = ir_q[31:26];
   assign rt    = ir_q[20:16];
   assign rd    = ir_q[15:11];
   assign shamt = ir_q[10:6];
   assign funct = ir_q[5:0];
   assign imm16 = ir_q[15:0];

   assign bus.op    = op;
   assign bus.funct = funct;
   assign bus.rs    = ir_q[25:21];
   assign bus.rt    = rt;
   assign bus.rd    = rd;
   assign bus.shamt = shamt;
   assign bus.imm16 = imm16;

   // Opcode/funct decode; the all-zero word is a NOP even though it aliases SLL.
   always_comb begin
      ctrl = ALU_NOP;
      if (ir_q != '0) begin
         case (op)
            OP_RTYPE: begin
               case (funct)
                  FN_ADD, FN_ADDU: ctrl = ALU_ADD;
                  FN_SUB, FN_SUBU: ctrl = ALU_SUB;
                  FN_AND:          ctrl = ALU_AND;
                  FN_OR:           ctrl = ALU_OR;
                  FN_XOR:          ctrl = ALU_XOR;
                  FN_NOR:          ctrl = ALU_NOR;
                  FN_SLT:          ctrl = ALU_SLT;
                  FN_SLTU:         ctrl = ALU_SLTU;
                  FN_SLL:          ctrl = ALU_SLL;
                  FN_SRL:          ctrl = ALU_SRL;
                  FN_SRA:          ctrl = ALU_SRA;
                  FN_SLLV:         ctrl = ALU_SLLV;
                  FN_SRLV:         ctrl = ALU_SRLV;
                  FN_SRAV:         ctrl = ALU_SRAV;
                  default:         ctrl = ALU_NOP;
               endcase
            end
            OP_ADDI, OP_ADDIU: ctrl = ALU_ADDI;
            OP_SLTI:           ctrl = ALU_SLTI;
            OP_SLTIU:          ctrl = ALU_SLTIU;
            OP_ANDI:           ctrl = ALU_ANDI;
            OP_ORI:            ctrl = ALU_ORI;
            OP_XORI:           ctrl = ALU_XORI;
            OP_LUI:            ctrl = ALU_LUI;
            default:           ctrl = ALU_NOP;
         endcase
      end
   end

   assign bus.alu_ctrl  = ctrl;
   assign bus.reg_write = (ctrl != ALU_NOP);
   assign bus.wr_addr   = (op == OP_RTYPE) ? rd : rt;

   assign imm_sext = {{HALF_W{imm16[IMM_W-1]}}, imm16};
   assign imm_zext = {{HALF_W{1'b0}}, imm16};
   assign var_sh   = bus.a[REG_W-1:0];

   // ALU: no overflow detection, compares return 0/1.
   always_comb begin
      result = '0;
      case (ctrl)
         ALU_ADD:   result = bus.a + bus.b;
         ALU_SUB:   result = bus.a - bus.b;
         ALU_AND:   result = bus.a & bus.b;
         ALU_OR:    result = bus.a | bus.b;
         ALU_XOR:   result = bus.a ^ bus.b;
         ALU_NOR:   result = ~(bus.a | bus.b);
         ALU_SLT:   result = WORD_WIDTH'($signed(bus.a) < $signed(bus.b));
         ALU_SLTU:  result = WORD_WIDTH'(bus.a < bus.b);
         ALU_SLL:   result = bus.b << shamt;
         ALU_SRL:   result = bus.b >> shamt;
         ALU_SRA:   result = WORD_WIDTH'($signed(bus.b) >>> shamt);
         ALU_SLLV:  result = bus.b << var_sh;
         ALU_SRLV:  result = bus.b >> var_sh;
         ALU_SRAV:  result = WORD_WIDTH'($signed(bus.b) >>> var_sh);
         ALU_ADDI:  result = bus.a + imm_sext;
         ALU_SLTI:  result = WORD_WIDTH'($signed(bus.a) < $signed(imm_sext));
         ALU_SLTIU: result = WORD_WIDTH'(bus.a < imm_sext);
         ALU_ANDI:  result = bus.a & imm_zext;
         ALU_ORI:   result = bus.a | imm_zext;
         ALU_XORI:  result = bus.a ^ imm_zext;
         ALU_LUI:   result = {imm16, {HALF_W{1'b0}}};
         default:   result = '0;
      endcase
   end

   assign bus.c = result;
   assign bus.z = (result == '0);

endmodule

// File: tb/tb_decode_execute_unit.sv
// Self-checking bench for decode_execute_unit: directed plan followed by random instructions
// checked against an instruction-level reference model.
module tb_decode_execute_unit;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   decode_execute_unit_if bus ();

   decode_execute_unit dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [31:0] ir_m;

   typedef struct {
      logic [4:0]  ctrl;
      logic        rw;
      logic [31:0] c;
   } exp_t;

   // Reference semantics of one instruction word with operands a/b.
   function automatic exp_t model(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  sh;
      logic [31:0] sx;
      logic [31:0] zx;
      logic [31:0] bias;
      op   = ir[31:26];
      fn   = ir[5:0];
      sh   = ir[10:6];
      zx   = {16'h0, ir[15:0]};
      sx   = ir[15] ? (zx | 32'hFFFF0000) : zx;
      bias = 32'h80000000;
      e.ctrl = 5'h00;
      e.c    = 32'h0;
      if (ir != 32'h0) begin
         if (op == 6'h00) begin
            case (fn)
               6'h20, 6'h21: begin e.ctrl = 5'h01; e.c = a + b; end
               6'h22, 6'h23: begin e.ctrl = 5'h02; e.c = a + ~b + 32'd1; end
               6'h24: begin e.ctrl = 5'h03; e.c = a & b; end
               6'h25: begin e.ctrl = 5'h04; e.c = a | b; end
               6'h26: begin e.ctrl = 5'h05; e.c = a ^ b; end
               6'h27: begin e.ctrl = 5'h06; e.c = ~a & ~b; end
               6'h2A: begin e.ctrl = 5'h07; e.c = ((a ^ bias) < (b ^ bias)) ? 32'd1 : 32'd0; end
               6'h2B: begin e.ctrl = 5'h08; e.c = (a < b) ? 32'd1 : 32'd0; end
               6'h00: begin e.ctrl = 5'h09; e.c = b * (32'd1 << sh); end
               6'h02: begin e.ctrl = 5'h0A; e.c = b / (32'd1 << sh); end
               6'h03: begin e.ctrl = 5'h0B; e.c = (b >> sh) | (b[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0); end
               6'h04: begin e.ctrl = 5'h0C; e.c = b * (32'd1 << a[4:0]); end
               6'h06: begin e.ctrl = 5'h0D; e.c = b / (32'd1 << a[4:0]); end
               6'h07: begin e.ctrl = 5'h0E; e.c = (b >> a[4:0]) | (b[31] ? ~(32'hFFFFFFFF >> a[4:0]) : 32'h0); end
               default: ;
            endcase
         end else begin
            case (op)
               6'h08, 6'h09: begin e.ctrl = 5'h10; e.c = a + sx; end
               6'h0A: begin e.ctrl = 5'h11; e.c = ((a ^ bias) < (sx ^ bias)) ? 32'd1 : 32'd0; end
               6'h0B: begin e.ctrl = 5'h12; e.c = (a < sx) ? 32'd1 : 32'd0; end
               6'h0C: begin e.ctrl = 5'h13; e.c = a & zx; end
               6'h0D: begin e.ctrl = 5'h14; e.c = a | zx; end
               6'h0E: begin e.ctrl = 5'h15; e.c = a ^ zx; end
               6'h0F: begin e.ctrl = 5'h16; e.c = zx << 16; end
               default: ;
            endcase
         end
      end
      e.rw = (e.ctrl != 5'h00);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic check_all(input string pfx);
      exp_t e;
      e = model(ir_m, bus.a, bus.b);
      chk({pfx, "_op"},    32'(bus.op),        32'(ir_m[31:26]));
      chk({pfx, "_rs"},    32'(bus.rs),        32'(ir_m[25:21]));
      chk({pfx, "_rt"},    32'(bus.rt),        32'(ir_m[20:16]));
      chk({pfx, "_rd"},    32'(bus.rd),        32'(ir_m[15:11]));
      chk({pfx, "_shamt"}, 32'(bus.shamt),     32'(ir_m[10:6]));
      chk({pfx, "_funct"}, 32'(bus.funct),     32'(ir_m[5:0]));
      chk({pfx, "_imm"},   32'(bus.imm16),     32'(ir_m[15:0]));
      chk({pfx, "_wra"},   32'(bus.wr_addr),   32'((ir_m[31:26] == 6'h00) ? ir_m[15:11] : ir_m[20:16]));
      chk({pfx, "_ctrl"},  32'(bus.alu_ctrl),  32'(e.ctrl));
      chk({pfx, "_rw"},    32'(bus.reg_write), 32'(e.rw));
      chk({pfx, "_c"},     bus.c,              e.c);
      chk({pfx, "_z"},     32'(bus.z),         32'(e.c == 32'h0));
   endtask

   task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      rst          = r;
      bus.instr_in = ins;
      bus.a        = av;
      bus.b        = bv;
      @(posedge clk);
      ir_m = r ? 32'h0 : ins;
      #1;
   endtask

   logic [5:0] r_fn [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                             6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04};
   logic [5:0] r_fn2 [2] = '{6'h06, 6'h07};
   logic [5:0] i_op [8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

   initial begin
      logic [31:0] ins;
      logic [31:0] av;
      logic [31:0] bv;
      logic        r;
      int unsigned sel;

      rst = 1'b1;
      bus.instr_in = 32'h00221820;
      bus.a = 32'd5;
      bus.b = 32'd7;
      ir_m = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctrl", 32'(bus.alu_ctrl), 32'h0);
      chk("rst_rw",   32'(bus.reg_write), 32'h0);
      chk("rst_c",    bus.c, 32'h0);
      chk("rst_z",    32'(bus.z), 32'h1);
      check_all("rst");

      step(1'b0, 32'h00221820, 32'd5, 32'd7);
      chk("add_c", bus.c, 32'd12);
      chk("add_z", 32'(bus.z), 32'h0);
      chk("add_wra", 32'(bus.wr_addr), 32'd3);
      chk("add_rw", 32'(bus.reg_write), 32'h1);
      chk("add_ctrl", 32'(bus.alu_ctrl), 32'h01);
      check_all("add");

      step(1'b0, 32'h00221822, 32'd9, 32'd9);
      chk("sub_c", bus.c, 32'h0);
      chk("sub_z", 32'(bus.z), 32'h1);
      // operand change without a clock edge
      bus.a = 32'd10;
      #1;
      chk("sub_async_c", bus.c, 32'd1);
      chk("sub_async_z", 32'(bus.z), 32'h0);

      step(1'b0, 32'h34228001, 32'h00010000, 32'h0);
      chk("ori_c", bus.c, 32'h00018001);
      chk("ori_wra", 32'(bus.wr_addr), 32'd2);
      step(1'b0, 32'h3C021234, 32'h0, 32'h0);
      chk("lui_c", bus.c, 32'h12340000);

      step(1'b0, 32'h2822FFFF, 32'hFFFFFFFE, 32'h0);
      chk("slti_c", bus.c, 32'd1);
      step(1'b0, 32'h2C22FFFF, 32'hFFFFFFFE, 32'h0);
      chk("sltiu_c", bus.c, 32'd1);
      step(1'b0, 32'h2C22FFFF, 32'hFFFFFFFF, 32'h0);
      chk("sltiu_eq_c", bus.c, 32'd0);
      chk("sltiu_eq_z", 32'(bus.z), 32'h1);

      step(1'b0, 32'h00021903, 32'h0, 32'h80000000);
      chk("sra_c", bus.c, 32'hF8000000);
      step(1'b0, 32'h00221806, 32'd36, 32'h80000000);
      chk("srlv_c", bus.c, 32'h08000000);

      step(1'b0, 32'hFC000000, 32'h12345678, 32'h9ABCDEF0);
      chk("badop_ctrl", 32'(bus.alu_ctrl), 32'h0);
      chk("badop_rw", 32'(bus.reg_write), 32'h0);
      chk("badop_c", bus.c, 32'h0);
      chk("badop_z", 32'(bus.z), 32'h1);
      step(1'b0, 32'h0022183F, 32'h12345678, 32'h9ABCDEF0);
      chk("badfn_ctrl", 32'(bus.alu_ctrl), 32'h0);
      chk("badfn_rw", 32'(bus.reg_write), 32'h0);
      chk("badfn_c", bus.c, 32'h0);
      chk("badfn_z", 32'(bus.z), 32'h1);

      // mid-stream reset discards the instruction presented with it
      step(1'b1, 32'h00221820, 32'd1, 32'd2);
      chk("midrst_ctrl", 32'(bus.alu_ctrl), 32'h0);
      chk("midrst_c", bus.c, 32'h0);
      chk("midrst_z", 32'(bus.z), 32'h1);
      check_all("midrst");

      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 11);
         ins = $urandom;
         av  = $urandom;
         bv  = (sel == 11) ? av : 32'($urandom);
         if (sel < 4)       ins[31:26] = 6'h00;
         if (sel < 3)       ins[5:0]   = r_fn[$urandom_range(0, 13)];
         else if (sel == 3) ins[5:0]   = r_fn2[$urandom_range(0, 1)];
         else if (sel < 8)  ins[31:26] = i_op[$urandom_range(0, 7)];
         else if (sel == 9) ins        = 32'h0;
         r = ($urandom_range(0, 19) == 0);
         step(r, ins, av, bv);
         check_all("rand");
         if ($urandom_range(0, 3) == 0) begin
            bus.a = $urandom;
            bus.b = $urandom_range(0, 1) ? 32'h0 : 32'($urandom);
            #1;
            check_all("rand_async");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
